// File: rtl/slow_mem_responder_pkg.sv
// Shared types and constants for the slow memory line responder.
//   LINE_W      : line width of the refill protocol (128 bits)
//   ADDR_W      : line address width, byte address bits [31:4]
//   smr_state_t : responder FSM states
//   smr_op_t    : latched request kind
package slow_mem_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} smr_state_t;
  typedef enum logic {OP_RD, OP_WR} smr_op_t;

endpackage

// File: rtl/slow_mem_responder_if.sv
// Cache line-refill bus between a cache (master) and a memory responder (slave).
//   mem_read / mem_write : request, held by the cache until mem_ready
//   mem_addr             : line address (byte address bits [31:4])
//   mem_wdata            : write line, stable while mem_write is high
//   mem_rdata            : read line from the responder
//   mem_ready            : one-cycle completion pulse from the responder
interface slow_mem_if #(
  parameter int LINE_W = slow_mem_pkg::LINE_W,
  parameter int ADDR_W = slow_mem_pkg::ADDR_W
);

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/slow_mem_responder_array.sv
// slow_mem_array: single-port line RAM, 2**DEPTH_LOG2 lines of LINE_W bits.
//   clk   : clock, rising edge
//   we    : write enable, line written at the end of the cycle
//   addr  : line index (shared by read and write)
//   wdata : write line
//   rdata : asynchronous read of the addressed line
// Contents are deliberately not reset.
module slow_mem_array #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LINE_W     = 128
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [LINE_W-1:0]     wdata,
  output logic [LINE_W-1:0]     rdata
);

  logic [LINE_W-1:0] line_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) line_q[addr] <= wdata;
  end

  assign rdata = line_q[addr];

endmodule

// File: rtl/slow_mem_responder.sv
// slow_mem_responder: serves 128-bit line reads/writes from a local array
// after a fixed LATENCY (1..255) cycles measured from the request sample edge
// to the mem_ready cycle.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus          : refill bus, slave side (slow_mem_if.slave)
//   stat_reads   : completed reads, saturating   (SLOW_MEM_STATS_EN only)
//   stat_writes  : completed writes, saturating  (SLOW_MEM_STATS_EN only)
// Optional feature macro: SLOW_MEM_STATS_EN (adds the statistics counters).
module slow_mem_responder
  import slow_mem_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int DEPTH_LOG2 = 8,
  parameter int LINE_W     = slow_mem_pkg::LINE_W
) (
  input  logic clk,
  input  logic rst_n,
  slow_mem_if.slave bus
`ifdef SLOW_MEM_STATS_EN
  ,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes
`endif
);

  smr_state_t            state_q, state_d;
  logic [7:0]            count_q, count_d;
  smr_op_t               op_q, op_d;
  logic                  rd_also_q, rd_also_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic                  ready_q, ready_d;
  logic [LINE_W-1:0]     rdata_q, rdata_d;

  logic                  resp;
  logic                  arr_we;
  logic [LINE_W-1:0]     arr_rdata;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^bus.mem_addr[ADDR_W-1:DEPTH_LOG2];

  slow_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LINE_W     (LINE_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (addr_q),
    .wdata (bus.mem_wdata),
    .rdata (arr_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= OP_RD;
      rd_also_q <= 1'b0;
      addr_q    <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      rd_also_q <= rd_also_d;
      addr_q    <= addr_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state logic. mem_ready is registered from RESP, so RESP sits one
  // cycle ahead of the pulse: WAIT lasts LATENCY-1 cycles and the pulse
  // coincides with TURN, which keeps consecutive pulses LATENCY+2 apart.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    rd_also_d = rd_also_q;
    addr_d    = addr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          op_d      = bus.mem_write ? OP_WR : OP_RD;
          rd_also_d = bus.mem_read;
          addr_d    = bus.mem_addr[DEPTH_LOG2-1:0];
          count_d   = 8'(LATENCY - 1);
          state_d   = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!bus.mem_read && !bus.mem_write) begin
          state_d = IDLE;
        end else if (count_q <= 8'd1) begin
          count_d = '0;
          state_d = RESP;
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      RESP:    state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. A combined read+write returns the pre-write line because the
  // asynchronous read and the array write share the same edge.
  always_comb begin
    resp    = (state_q == RESP);
    arr_we  = resp && (op_q == OP_WR);
    ready_d = resp;
    rdata_d = rdata_q;
    if (resp && ((op_q == OP_RD) || rd_also_q)) rdata_d = arr_rdata;
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;

`ifdef SLOW_MEM_STATS_EN
  logic [31:0] stat_reads_q, stat_reads_d;
  logic [31:0] stat_writes_q, stat_writes_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    if (resp && (op_q == OP_RD)) stat_reads_d  = sat_inc(stat_reads_q);
    if (resp && (op_q == OP_WR)) stat_writes_d = sat_inc(stat_writes_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_slow_mem_responder.sv
module tb_slow_mem_responder;
  import slow_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  slow_mem_if bus_a ();
  slow_mem_if bus_b ();

`ifdef SLOW_MEM_STATS_EN
  logic [31:0] sr_a, sw_a, sr_b, sw_b;
`endif

  slow_mem_responder #(.LATENCY(10), .DEPTH_LOG2(8)) u_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
`ifdef SLOW_MEM_STATS_EN
    , .stat_reads (sr_a), .stat_writes (sw_a)
`endif
  );

  slow_mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) u_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
`ifdef SLOW_MEM_STATS_EN
    , .stat_reads (sr_b), .stat_writes (sw_b)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit b, input logic rd, input logic wr,
                         input logic [27:0] a, input logic [127:0] d);
    if (b) begin
      bus_b.mem_read = rd; bus_b.mem_write = wr; bus_b.mem_addr = a; bus_b.mem_wdata = d;
    end else begin
      bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.mem_addr = a; bus_a.mem_wdata = d;
    end
  endtask

  function automatic logic get_ready(input bit b);
    return b ? bus_b.mem_ready : bus_a.mem_ready;
  endfunction

  function automatic logic [127:0] get_rdata(input bit b);
    return b ? bus_b.mem_rdata : bus_a.mem_rdata;
  endfunction

  // Called at a negedge with the request already driven. Consumes the
  // sample edge, then counts edges until mem_ready is seen (bounded).
  task automatic wait_ready(input bit b, output int n, output logic [127:0] rd);
    n = 0;
    @(posedge clk);
    @(negedge clk);
    while (!get_ready(b) && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    rd = get_rdata(b);
  endtask

  task automatic txn(input bit b, input logic rd, input logic wr, input logic [27:0] a,
                     input logic [127:0] d, input int exp_lat, input logic [127:0] exp_rdata,
                     input string name);
    int n;
    logic [127:0] r;
    set_req(b, rd, wr, a, d);
    wait_ready(b, n, r);
    chk({name, " latency"}, 128'(n), 128'(exp_lat));
    chk({name, " rdata"}, r, exp_rdata);
    if (!b && n < 300) begin
      if (wr) exp_wr++;
      else    exp_rd++;
    end
    set_req(b, 1'b0, 1'b0, a, d);
    @(negedge clk);
    chk({name, " single pulse"}, 128'(get_ready(b)), 128'd0);
  endtask

  initial begin
    int n;
    logic [127:0] r;
    bit seen;

    vecs[0] = '{1'b0, 1'b1, 28'h0000010, {16{8'hA5}}, 128'd0};
    vecs[1] = '{1'b1, 1'b0, 28'h0000010, 128'd0, {16{8'hA5}}};
    vecs[2] = '{1'b0, 1'b1, 28'h0000100, {32{4'h1}}, {16{8'hA5}}};
    vecs[3] = '{1'b1, 1'b0, 28'h0000000, 128'd0, {32{4'h1}}};
    vecs[4] = '{1'b0, 1'b1, 28'h0000020, {16{8'hC3}}, {32{4'h1}}};
    vecs[5] = '{1'b1, 1'b0, 28'h0000020, 128'd0, {16{8'hC3}}};
    vecs[6] = '{1'b0, 1'b1, 28'h0000030, {8{16'h1234}}, {16{8'hC3}}};
    vecs[7] = '{1'b1, 1'b0, 28'h0000010, 128'd0, {16{8'hA5}}};
    vecs[8] = '{1'b0, 1'b1, 28'h00000FF, {2{64'h0123_4567_89AB_CDEF}}, {16{8'hA5}}};
    vecs[9] = '{1'b1, 1'b0, 28'h00008FF, 128'd0, {2{64'h0123_4567_89AB_CDEF}}};

    set_req(1'b0, 1'b0, 1'b0, 28'd0, 128'd0);
    set_req(1'b1, 1'b0, 1'b0, 28'd0, 128'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready", 128'(bus_a.mem_ready), 128'd0);
    chk("reset rdata", bus_a.mem_rdata, 128'd0);
    chk("reset ready b", 128'(bus_b.mem_ready), 128'd0);
`ifdef SLOW_MEM_STATS_EN
    chk("reset stat_reads", 128'(sr_a), 128'd0);
    chk("reset stat_writes", 128'(sw_a), 128'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table: writes/reads incl. aliasing and rdata hold through writes
    for (int i = 0; i < 10; i++) begin
      txn(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 10,
          vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end

    // Request held through mem_ready: two pulses LATENCY+2 apart
    set_req(1'b0, 1'b1, 1'b0, 28'h20, 128'd0);
    wait_ready(1'b0, n, r);
    chk("hold first latency", 128'(n), 128'd10);
    chk("hold first rdata", r, {16{8'hC3}});
    n = 0;
    @(posedge clk); n++; @(negedge clk);
    while (!bus_a.mem_ready && n < 300) begin
      @(posedge clk); n++; @(negedge clk);
    end
    chk("hold pulse spacing", 128'(n), 128'd12);
    exp_rd += 2;
    set_req(1'b0, 1'b0, 1'b0, 28'h20, 128'd0);
    @(negedge clk);

    // Withdrawn write at WAIT cycle 5
    set_req(1'b0, 1'b0, 1'b1, 28'h20, {16{8'hFF}});
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, 28'h20, {16{8'hFF}});
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus_a.mem_ready) seen = 1'b1;
    end
    chk("withdraw no ready", 128'(seen), 128'd0);
    txn(1'b0, 1'b1, 1'b0, 28'h20, 128'd0, 10, {16{8'hC3}}, "after withdraw");

    // Read+write together: write lands, pre-write line returned
    txn(1'b0, 1'b1, 1'b1, 28'h30, {8{16'h5678}}, 10, {8{16'h1234}}, "rw both");
    txn(1'b0, 1'b1, 1'b0, 28'h30, 128'd0, 10, {8{16'h5678}}, "rw readback");

    // Address changed after sample is ignored
    set_req(1'b0, 1'b1, 1'b0, 28'h10, 128'd0);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_a.mem_addr = 28'h20;
    while (!bus_a.mem_ready && n < 600) begin
      @(posedge clk); n++; @(negedge clk);
    end
    chk("addr latched rdata", bus_a.mem_rdata, {16{8'hA5}});
    exp_rd++;
    set_req(1'b0, 1'b0, 1'b0, 28'h0, 128'd0);
    repeat (2) @(negedge clk);

    // Reset during WAIT of a write: dropped, array unchanged
    set_req(1'b0, 1'b0, 1'b1, 28'h20, {16{8'hBB}});
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset mid ready", 128'(bus_a.mem_ready), 128'd0);
    chk("reset mid rdata", bus_a.mem_rdata, 128'd0);
    exp_rd = 0;
    exp_wr = 0;
    set_req(1'b0, 1'b0, 1'b0, 28'h20, {16{8'hBB}});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1'b0, 1'b1, 1'b0, 28'h20, 128'd0, 10, {16{8'hC3}}, "after reset");

    // LATENCY=1 instance
    txn(1'b1, 1'b0, 1'b1, 28'h5, {16{8'h77}}, 1, 128'd0, "lat1 write");
    txn(1'b1, 1'b1, 1'b0, 28'h5, 128'd0, 1, {16{8'h77}}, "lat1 read");

`ifdef SLOW_MEM_STATS_EN
    chk("stat_reads", 128'(sr_a), 128'(exp_rd));
    chk("stat_writes", 128'(sw_a), 128'(exp_wr));
    chk("stat_reads b", 128'(sr_b), 128'd1);
    chk("stat_writes b", 128'(sw_b), 128'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
